// File: rtl/mem_port_arbiter_if.sv
// Fetch-stage, memory-stage and memory-side signals of the shared memory port.
// The master view belongs to the arbiter; the slave view belongs to the core and memory.
interface mem_port_arbiter_if;
    // fetch stage
    logic        IReqF;
    logic [31:0] PCF;
    logic [31:0] InstrF;
    logic        IAckF;
    logic        StallMemF;
    // memory stage
    logic        MemReadM;
    logic        MemWriteM;
    logic        MemByteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        DAckM;
    logic        StallMemM;
    // memory
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        input  IReqF, PCF, MemReadM, MemWriteM, MemByteM, ALUOutM, WriteDataM,
        input  mem_rdata, mem_ready,
        output InstrF, IAckF, StallMemF, ReadDataM, DAckM, StallMemM,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        output IReqF, PCF, MemReadM, MemWriteM, MemByteM, ALUOutM, WriteDataM,
        output mem_rdata, mem_ready,
        input  InstrF, IAckF, StallMemF, ReadDataM, DAckM, StallMemM,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and data access.
// Data has priority; a fetch is forced through after STARVE_LIMIT data grants made while it waits.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.master bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        INSTR = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic [1:0]  byte_off_q, byte_off_d;
    logic        byte_ld_q, byte_ld_d;

    logic        dreq;
    logic        fetch_wins;
    logic        fetch_grant;
    logic        data_grant;
    logic        byte_store;
    logic [7:0]  sel_byte;

    assign dreq        = bus.MemReadM | bus.MemWriteM;
    // At the starvation limit a waiting fetch overrides the normal data-first priority.
    assign fetch_wins  = bus.IReqF & (~dreq | (starve_cnt_q == LIMIT));
    assign fetch_grant = (state_q == IDLE) & fetch_wins;
    assign data_grant  = (state_q == IDLE) & dreq & ~fetch_wins;
    assign byte_store  = bus.MemWriteM & bus.MemByteM;

    // State and request registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_be_q     <= 4'h0;
            mem_wdata_q  <= 32'h0;
            starve_cnt_q <= 4'h0;
            byte_off_q   <= 2'b00;
            byte_ld_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            starve_cnt_q <= starve_cnt_d;
            byte_off_q   <= byte_off_d;
            byte_ld_q    <= byte_ld_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned and infers a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fetch_grant) begin
                    state_d = INSTR;
                end else if (data_grant) begin
                    state_d = DATA;
                end
            end
            DATA, INSTR: begin
                if (bus.mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture at grant time and starvation bookkeeping
    always_comb begin
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        starve_cnt_d = starve_cnt_q;
        byte_off_d   = byte_off_q;
        byte_ld_d    = byte_ld_q;

        if (state_q == IDLE) begin
            mem_req_d = fetch_grant | data_grant;
        end else if (bus.mem_ready) begin
            mem_req_d = 1'b0;
        end

        if (fetch_grant) begin
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.PCF & 32'hFFFF_FFFC;
            mem_be_d    = 4'hF;
            mem_wdata_d = 32'h0;
            byte_ld_d   = 1'b0;
        end else if (data_grant) begin
            mem_we_d    = bus.MemWriteM;
            mem_addr_d  = bus.ALUOutM & 32'hFFFF_FFFC;
            mem_be_d    = byte_store ? (4'b0001 << bus.ALUOutM[1:0]) : 4'hF;
            mem_wdata_d = byte_store ? {4{bus.WriteDataM[7:0]}} : bus.WriteDataM;
            byte_off_d  = bus.ALUOutM[1:0];
            byte_ld_d   = ~bus.MemWriteM & bus.MemByteM;
        end

        // Counts data grants that overtook a waiting fetch; saturates at the limit.
        if (state_q == IDLE) begin
            if (fetch_grant || !bus.IReqF) begin
                starve_cnt_d = 4'h0;
            end else if (data_grant && (starve_cnt_q < LIMIT)) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end

    always_comb begin
        sel_byte = bus.mem_rdata[7:0];
        unique case (byte_off_q)
            2'd0: sel_byte = bus.mem_rdata[7:0];
            2'd1: sel_byte = bus.mem_rdata[15:8];
            2'd2: sel_byte = bus.mem_rdata[23:16];
            2'd3: sel_byte = bus.mem_rdata[31:24];
            default: sel_byte = bus.mem_rdata[7:0];
        endcase
    end

    // Acks and returned data are combinational from mem_ready in the serving state
    always_comb begin
        bus.IAckF     = 1'b0;
        bus.InstrF    = 32'h0;
        bus.DAckM     = 1'b0;
        bus.ReadDataM = 32'h0;
        unique case (state_q)
            INSTR: begin
                if (bus.mem_ready) begin
                    bus.IAckF  = 1'b1;
                    bus.InstrF = bus.mem_rdata;
                end
            end
            DATA: begin
                if (bus.mem_ready) begin
                    bus.DAckM     = 1'b1;
                    bus.ReadDataM = byte_ld_q ? {24'h0, sel_byte} : bus.mem_rdata;
                end
            end
            default: begin
                bus.IAckF = 1'b0;
                bus.DAckM = 1'b0;
            end
        endcase
        bus.StallMemF = bus.IReqF & ~bus.IAckF;
        bus.StallMemM = dreq & ~bus.DAckM;
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter that lets the pipelined core share one single-ported, variable-latency memory between the fetch stage (instruction reads) and the memory stage (data loads/stores). It sits between the core's fetch/memory-stage signals and the memory. It issues registered memory requests and returns completion acks, and it produces per-stage stall outputs. The hazard unit ORs these stall outputs into StallF and into the pipeline stall for M and the older stages.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch is pending before the fetch is forced through (1-15).

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- IReqF  in  1  fetch request
- PCF  in  32  fetch address (word-aligned)
- InstrF  out  32  fetched instruction; valid only while IAckF=1
- IAckF  out  1  fetch complete this cycle
- StallMemF  out  1  IReqF & ~IAckF
- MemReadM  in  1  load request
- MemWriteM  in  1  store request
- MemByteM  in  1  byte access (else word)
- ALUOutM  in  32  data address
- WriteDataM  in  32  store data
- ReadDataM  out  32  load data; valid only while DAckM=1
- DAckM  out  1  data access complete this cycle
- StallMemM  out  1  (MemReadM|MemWriteM) & ~DAckM
- mem_req  out  1  request to memory (registered)
- mem_we  out  1  write enable (registered)
- mem_addr  out  32  word address, bits [1:0] forced 0 (registered)
- mem_be  out  4  byte enables (registered)
- mem_wdata  out  32  write data (registered)
- mem_rdata  in  32  memory read data
- mem_ready  in  1  memory completes the current request this cycle

## Operation
- FSM states: IDLE, DATA, INSTR. DReq = MemReadM | MemWriteM. If both MemReadM and MemWriteM are asserted, it is treated as a write.
- IDLE: evaluate requests every cycle.
  - Priority is data over fetch, except when starve_cnt == STARVE_LIMIT and IReqF=1; in that case the fetch wins.
  - On a grant, register mem_addr, mem_we, mem_be and mem_wdata from the winning requester, set mem_req=1, and enter DATA or INSTR.
  - With no request, stay in IDLE with mem_req=0.
- DATA/INSTR: hold all mem_* outputs stable until mem_ready=1. Requester inputs are ignored after the grant.
- On the cycle mem_ready=1 in DATA/INSTR:
  - Pulse DAckM or IAckF combinationally.
  - Drive ReadDataM or InstrF from mem_rdata.
  - Deassert mem_req at the next edge and return to IDLE.
- A completed access always passes through IDLE for one cycle; there are no back-to-back grants.
- Byte stores:
  - mem_be = one-hot of ALUOutM[1:0]: 00→0001, 01→0010, 10→0100, 11→1000.
  - mem_wdata = WriteDataM[7:0] replicated four times.
- Word stores and all loads: mem_be = 1111; mem_wdata = WriteDataM.
- Byte loads: ReadDataM = zero-extended byte selected by a latched copy of addr[1:0] (0x000000xx). Word loads: ReadDataM = mem_rdata.
- Fetches: mem_be = 1111, mem_we = 0.
- starve_cnt (4-bit) update rules:
  - +1 on each data grant made while IReqF=1.
  - Cleared on any fetch grant.
  - Cleared in IDLE when IReqF=0.
  - Saturates at STARVE_LIMIT.
- Ack outputs are 0 in IDLE. No ack is produced for a state the FSM is not in.

## Timing
- Reset values: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_be 0, mem_wdata 0, starve_cnt 0, latched byte offset 0. IAckF, DAckM, InstrF and ReadDataM read 0 while in reset.
- Reset mid-access: outputs clear immediately (asynchronously). The memory sees mem_req drop, and the in-flight access is abandoned without an ack.
- Latency:
  - Request sampled in IDLE at cycle t → mem_req=1 from t+1.
  - Ack at the first cycle ≥ t+1 with mem_ready=1.
  - Minimum 2 cycles per access. Two idle-free fetches therefore complete at most every 2 cycles.
- Requesters hold request, address and data until they see ack. The pipeline advances on the ack edge and presents the next request, which IDLE samples on the following cycle.
- Simultaneous IReqF and DReq in IDLE: data is served first and StallMemF stays high through both accesses. The fetch is granted in the IDLE cycle after DAckM, unless a new data request arrives while starve_cnt < STARVE_LIMIT.
- mem_ready asserted in IDLE is ignored.

## Test plan
- Fetch only, mem_ready tied 1, PCF 0x0→0x4→0x8 advancing on each IAckF → IAckF every 2nd cycle, mem_addr 0x0, 0x4, 0x8, StallMemF high exactly in the grant cycles.
- IReqF (PCF=0x20) and MemWriteM (ALUOutM=0x100, WriteDataM=0xDEADBEEF) together in IDLE → first grant mem_we=1, mem_addr=0x100, mem_be=1111, mem_wdata=0xDEADBEEF; DAckM, then IDLE, then fetch of 0x20 with IAckF.
- Continuous data requests plus pending fetch, STARVE_LIMIT=4 → four data grants, then the fetch is granted, then the counter clears and data resumes.
- Byte store ALUOutM=0x103, WriteDataM=0x000000AB → mem_addr=0x100, mem_be=1000, mem_wdata=0xABABABAB. Byte load from 0x102 with mem_rdata=0x11223344 → ReadDataM=0x00000022.
- mem_ready low for 3 cycles during a load of 0x40 → mem_req/mem_addr stable, StallMemM high 4 cycles, DAckM on the first ready cycle with ReadDataM=mem_rdata.
- Assert reset during DATA with mem_ready low → mem_req and mem_* drop to 0 immediately, no DAckM. After release, a pending request is re-arbitrated from IDLE.
